// File: rtl/load_store_unit.sv
// Sequences one data-memory load or store over a ready-handshaked bus with a
// wait-state timeout, and returns load data to register-file port B.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic        LS_OP,
    input  logic        LS_BYTE,
    input  logic [15:0] ADDR,
    input  logic [15:0] WDATA,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_DOUT,
    input  logic [15:0] MEM_DIN,
    output logic        MEM_RD,
    output logic        MEM_WR,
    output logic [1:0]  MEM_BE,
    input  logic        MEM_RDY,
    output logic [15:0] DIN,
    output logic        REGB_WEN,
    output logic        BUSY,
    output logic        DONE,
    output logic        BUS_ERR
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WB     = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_op, w_op_nxt;
    logic          r_byte, w_byte_nxt;
    logic          r_err, w_err_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [AW-1:0] r_addr, w_addr_nxt;
    logic [DW-1:0] r_dout, w_dout_nxt;
    logic [DW-1:0] r_din, w_din_nxt;
    logic          r_rd, w_rd_nxt;
    logic          r_wr, w_wr_nxt;
    logic [1:0]    r_be, w_be_nxt;
    logic          r_wen, w_wen_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          r_berr, w_berr_nxt;

    // State, captured request and all outputs are registered together.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_op    <= 1'b0;
            r_byte  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_dout  <= '0;
            r_din   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_be    <= 2'b00;
            r_wen   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_berr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_byte  <= w_byte_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_dout  <= w_dout_nxt;
            r_din   <= w_din_nxt;
            r_rd    <= w_rd_nxt;
            r_wr    <= w_wr_nxt;
            r_be    <= w_be_nxt;
            r_wen   <= w_wen_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_berr  <= w_berr_nxt;
        end
    end

    // Next state plus next-cycle outputs, decoded from the next state so that
    // every output is a flop with no input-to-output combinational path.
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_byte_nxt  = r_byte;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_dout_nxt  = r_dout;
        w_din_nxt   = r_din;

        unique case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_op_nxt   = LS_OP;
                    w_byte_nxt = LS_BYTE;
                    w_addr_nxt = ADDR;
                    w_dout_nxt = LS_BYTE ? {WDATA[7:0], WDATA[7:0]} : WDATA;
                    if (!LS_BYTE && ADDR[0]) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_FIN;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (MEM_RDY) begin
                    if (!r_op) begin
                        if (r_byte) begin
                            w_din_nxt = r_addr[0] ? {8'h00, MEM_DIN[15:8]}
                                                  : {8'h00, MEM_DIN[7:0]};
                        end else begin
                            w_din_nxt = MEM_DIN;
                        end
                        w_state_nxt = S_WB;
                    end else begin
                        w_state_nxt = S_FIN;
                    end
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_FIN;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_WB: begin
                w_state_nxt = S_IDLE;
            end
            S_FIN: begin
                w_err_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_rd_nxt   = (w_state_nxt == S_ACCESS) && !w_op_nxt;
        w_wr_nxt   = (w_state_nxt == S_ACCESS) && w_op_nxt;
        w_be_nxt   = 2'b00;
        if (w_state_nxt == S_ACCESS) begin
            w_be_nxt = !w_byte_nxt ? 2'b11 : (w_addr_nxt[0] ? 2'b10 : 2'b01);
        end
        w_wen_nxt  = (w_state_nxt == S_WB);
        w_done_nxt = (w_state_nxt == S_WB) || (w_state_nxt == S_FIN);
        w_berr_nxt = (w_state_nxt == S_FIN) && w_err_nxt;
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign MEM_ADDR = r_addr;
    assign MEM_DOUT = r_dout;
    assign MEM_RD   = r_rd;
    assign MEM_WR   = r_wr;
    assign MEM_BE   = r_be;
    assign DIN      = r_din;
    assign REGB_WEN = r_wen;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign BUS_ERR  = r_berr;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a
// transaction-level model of access length, error outcome and load result.
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0;
    logic        LS_OP = 1'b0;
    logic        LS_BYTE = 1'b0;
    logic [15:0] ADDR = '0;
    logic [15:0] WDATA = '0;
    logic [15:0] MEM_ADDR;
    logic [15:0] MEM_DOUT;
    logic [15:0] MEM_DIN = '0;
    logic        MEM_RD;
    logic        MEM_WR;
    logic [1:0]  MEM_BE;
    logic        MEM_RDY = 1'b0;
    logic [15:0] DIN;
    logic        REGB_WEN;
    logic        BUSY;
    logic        DONE;
    logic        BUS_ERR;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_din = '0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .LS_OP(LS_OP),
        .LS_BYTE(LS_BYTE), .ADDR(ADDR), .WDATA(WDATA), .MEM_ADDR(MEM_ADDR),
        .MEM_DOUT(MEM_DOUT), .MEM_DIN(MEM_DIN), .MEM_RD(MEM_RD),
        .MEM_WR(MEM_WR), .MEM_BE(MEM_BE), .MEM_RDY(MEM_RDY), .DIN(DIN),
        .REGB_WEN(REGB_WEN), .BUSY(BUSY), .DONE(DONE), .BUS_ERR(BUS_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd"}, 32'(MEM_RD), 0);
        chk({tag, "_wr"}, 32'(MEM_WR), 0);
        chk({tag, "_be"}, 32'(MEM_BE), 0);
        chk({tag, "_addr"}, 32'(MEM_ADDR), 0);
        chk({tag, "_dout"}, 32'(MEM_DOUT), 0);
        chk({tag, "_din"}, 32'(DIN), 0);
        chk({tag, "_wen"}, 32'(REGB_WEN), 0);
        chk({tag, "_busy"}, 32'(BUSY), 0);
        chk({tag, "_done"}, 32'(DONE), 0);
        chk({tag, "_berr"}, 32'(BUS_ERR), 0);
    endtask

    // Called at a negedge in an idle cycle; returns at the negedge of the idle
    // cycle following completion. wait_n = MEM_RDY-low cycles before ready.
    task automatic do_txn(input logic op, input logic byt, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] rdata,
                          input int wait_n, input logic junk_start);
        logic        misal;
        logic        err;
        int          n_acc;
        logic [1:0]  be_e;
        logic [15:0] dout_e;
        logic [15:0] load_e;

        misal  = !byt && addr[0];
        if (misal) begin
            n_acc = 0;
            err   = 1'b1;
        end else if (wait_n < int'(TO)) begin
            n_acc = wait_n + 1;
            err   = 1'b0;
        end else begin
            n_acc = int'(TO);
            err   = 1'b1;
        end
        be_e   = byt ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
        dout_e = byt ? {wdata[7:0], wdata[7:0]} : wdata;
        load_e = byt ? (addr[0] ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]}) : rdata;

        START = 1'b1; LS_OP = op; LS_BYTE = byt; ADDR = addr; WDATA = wdata;
        MEM_RDY = 1'b0;
        @(negedge CLK);
        for (int k = 0; k < n_acc; k++) begin
            START   = junk_start ? 1'($urandom) : 1'b0;
            LS_OP   = 1'($urandom);
            LS_BYTE = 1'($urandom);
            ADDR    = 16'($urandom);
            WDATA   = 16'($urandom);
            MEM_RDY = (k == wait_n);
            MEM_DIN = (k == wait_n) ? rdata : 16'($urandom);
            chk("acc_rd", 32'(MEM_RD), 32'(!op));
            chk("acc_wr", 32'(MEM_WR), 32'(op));
            chk("acc_be", 32'(MEM_BE), 32'(be_e));
            chk("acc_addr", 32'(MEM_ADDR), 32'(addr));
            if (op) chk("acc_dout", 32'(MEM_DOUT), 32'(dout_e));
            chk("acc_busy", 32'(BUSY), 1);
            chk("acc_done", 32'(DONE), 0);
            chk("acc_din_hold", 32'(DIN), 32'(exp_din));
            @(negedge CLK);
        end
        MEM_RDY = 1'b0;
        START   = junk_start ? 1'($urandom) : 1'b0;
        if (!op && !err) exp_din = load_e;
        chk("fin_done", 32'(DONE), 1);
        chk("fin_berr", 32'(BUS_ERR), 32'(err));
        chk("fin_wen", 32'(REGB_WEN), 32'(!op && !err));
        chk("fin_din", 32'(DIN), 32'(exp_din));
        chk("fin_strobes", 32'({MEM_RD, MEM_WR}), 0);
        chk("fin_busy", 32'(BUSY), 1);
        @(negedge CLK);
        START = 1'b0;
        chk("idle_busy", 32'(BUSY), 0);
        chk("idle_done", 32'(DONE), 0);
        chk("idle_wen", 32'(REGB_WEN), 0);
        chk("idle_berr", 32'(BUS_ERR), 0);
        chk("idle_din", 32'(DIN), 32'(exp_din));
    endtask

    initial begin
        #3;
        chk_reset_vals("rst");
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk_reset_vals("post_rst");

        // Directed cases
        do_txn(1'b0, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 0, 1'b0);
        do_txn(1'b0, 1'b1, 16'h0101, 16'h0000, 16'hA55A, 0, 1'b0);
        do_txn(1'b0, 1'b1, 16'h0100, 16'h0000, 16'hA55A, 0, 1'b0);
        do_txn(1'b1, 1'b1, 16'h2001, 16'h1277, 16'h0000, 3, 1'b0);
        do_txn(1'b0, 1'b0, 16'h4000, 16'h0000, 16'h1111, 99, 1'b0);
        do_txn(1'b0, 1'b0, 16'h4002, 16'h0000, 16'h2222, int'(TO) - 1, 1'b0);
        do_txn(1'b1, 1'b0, 16'h0003, 16'hCAFE, 16'h0000, 0, 1'b1);
        do_txn(1'b1, 1'b0, 16'h0006, 16'hCAFE, 16'h0000, 1, 1'b1);

        // Random traffic with ignored START pulses while busy
        for (int i = 0; i < 300; i++) begin
            do_txn(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                   16'($urandom), int'($urandom_range(0, TO + 1)), 1'b1);
        end

        // Asynchronous reset in the middle of an access
        START = 1'b1; LS_OP = 1'b0; LS_BYTE = 1'b0; ADDR = 16'h0010; MEM_RDY = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        chk("pre_abort_rd", 32'(MEM_RD), 1);
        #2 RESET_N = 1'b0;
        #1 chk_reset_vals("abort");
        @(negedge CLK);
        chk("abort_done", 32'(DONE), 0);
        RESET_N = 1'b1;
        exp_din = '0;
        @(negedge CLK);
        chk_reset_vals("abort_rel");
        do_txn(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h5A5A, 0, 1'b0);
        do_txn(1'b1, 1'b0, 16'h0022, 16'h9876, 16'h0000, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
